// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS/HSIZE encodings and index-width helper.
package ahb_pkg;

  localparam logic [1:0] HtransIdle   = 2'd0;
  localparam logic [1:0] HtransBusy   = 2'd1;
  localparam logic [1:0] HtransNonseq = 2'd2;
  localparam logic [1:0] HtransSeq    = 2'd3;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  // Width of a master index; never zero so single-bit vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// AHB arbiter bus bundle: per-master request/address inputs and muxed bus outputs.
// AHB_ARB_LOCK_EN adds HLOCK and HMASTLOCK.
interface ahb_arbiter_if #(
  parameter int unsigned NumMasters = 2
);
  import ahb_pkg::*;

  localparam int unsigned IdxW = idx_width(NumMasters);

  logic [NumMasters-1:0]       HBUSREQ;
  logic [NumMasters-1:0][31:0] M_HADDR;
  logic [NumMasters-1:0][1:0]  M_HTRANS;
  logic [NumMasters-1:0]       M_HWRITE;
  logic [NumMasters-1:0][2:0]  M_HSIZE;
  logic [NumMasters-1:0][31:0] M_HWDATA;
  logic                        HREADY;

  logic [NumMasters-1:0]       HGRANT;
  logic [IdxW-1:0]             HMASTER;
  logic [31:0]                 HADDR;
  logic [1:0]                  HTRANS;
  logic                        HWRITE;
  logic [2:0]                  HSIZE;
  logic [31:0]                 HWDATA;

`ifdef AHB_ARB_LOCK_EN
  logic [NumMasters-1:0]       HLOCK;
  logic                        HMASTLOCK;

  modport slave (
    input  HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, HREADY, HLOCK,
    output HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTLOCK
  );

  modport master (
    output HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, HREADY, HLOCK,
    input  HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTLOCK
  );
`else
  modport slave (
    input  HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, HREADY,
    output HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport master (
    output HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, HREADY,
    input  HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
`endif

endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i (wrapping), the
// last owner considered last; park index when nobody requests.
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int unsigned NumMasters = 2,
  parameter int unsigned IdxW       = idx_width(NumMasters)
) (
  input  logic [NumMasters-1:0] req_i,
  input  logic [IdxW-1:0]       last_i,
  input  logic [IdxW-1:0]       park_i,
  output logic [NumMasters-1:0] pick_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  // Scan last+1 .. last+NumMasters; the final candidate is last_i itself.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NumMasters; k++) begin
      cand = IdxW'((32'(last_i) + k) % NumMasters);
      if (!found && req_i[cand]) begin
        pick_o[cand] = 1'b1;
        found        = 1'b1;
      end
    end
    if (!found) begin
      pick_o[park_i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB round-robin arbiter with burst protection and per-tenure NONSEQ limit.
// Address/control follow the address-phase owner, HWDATA the data-phase owner.
// Optional AHB_ARB_LOCK_EN: HLOCK inhibits re-arbitration (plus one edge), HMASTLOCK out.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NumMasters = 2,
  parameter int unsigned ParkMaster = 0,
  parameter int unsigned MaxHold    = 8
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_arbiter_if.slave bus
);

  localparam int unsigned           IdxW      = idx_width(NumMasters);
  localparam logic [IdxW-1:0]       ParkIdx   = IdxW'(ParkMaster);
  localparam logic [NumMasters-1:0] ParkGrant = NumMasters'(1) << ParkMaster;
  localparam logic [7:0]            HoldMax   = 8'(MaxHold);

  logic [NumMasters-1:0] grant_q, grant_d, pick;
  logic [IdxW-1:0]       addr_owner_q, addr_owner_d;
  logic [IdxW-1:0]       data_owner_q, data_owner_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [IdxW-1:0]       grant_idx;
  logic [1:0]            htrans;
  logic                  in_burst, others_req, rearb;

`ifdef AHB_ARB_LOCK_EN
  logic lock_pend_q, lock_pend_d;
  logic locked;
`endif

  assign htrans = bus.M_HTRANS[addr_owner_q];

  assign bus.HGRANT  = grant_q;
  assign bus.HMASTER = addr_owner_q;
  assign bus.HADDR   = bus.M_HADDR[addr_owner_q];
  assign bus.HTRANS  = htrans;
  assign bus.HWRITE  = bus.M_HWRITE[addr_owner_q];
  assign bus.HSIZE   = bus.M_HSIZE[addr_owner_q];
  assign bus.HWDATA  = bus.M_HWDATA[data_owner_q];

  // One-hot grant to index.
  always_comb begin
    grant_idx = '0;
    for (int unsigned k = 0; k < NumMasters; k++) begin
      if (grant_q[k]) grant_idx = IdxW'(k);
    end
  end

  ahb_rr_pick #(
    .NumMasters(NumMasters),
    .IdxW      (IdxW)
  ) u_pick (
    .req_i (bus.HBUSREQ),
    .last_i(grant_idx),
    .park_i(ParkIdx),
    .pick_o(pick)
  );

`ifdef AHB_ARB_LOCK_EN
  assign locked        = bus.HLOCK[grant_idx];
  assign bus.HMASTLOCK = bus.HLOCK[addr_owner_q];
`endif

  // Re-arbitration is never allowed mid-burst.
  always_comb begin
    in_burst   = (htrans == HtransSeq) || (htrans == HtransBusy);
    others_req = |(bus.HBUSREQ & ~grant_q);
    rearb      = !in_burst &&
                 (!bus.HBUSREQ[grant_idx] || ((hold_cnt_q == HoldMax) && others_req));
`ifdef AHB_ARB_LOCK_EN
    if (locked || lock_pend_q) rearb = 1'b0;
`endif
  end

  // Next state: everything advances only on HREADY-qualified edges.
  always_comb begin
    grant_d      = grant_q;
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    hold_cnt_d   = hold_cnt_q;
`ifdef AHB_ARB_LOCK_EN
    lock_pend_d  = lock_pend_q;
`endif
    if (bus.HREADY) begin
      addr_owner_d = grant_idx;
      data_owner_d = addr_owner_q;
      if (rearb) grant_d = pick;
      if (grant_d != grant_q) begin
        hold_cnt_d = '0;
      end else if ((htrans == HtransNonseq) && (hold_cnt_q != HoldMax)) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
`ifdef AHB_ARB_LOCK_EN
      // Keep the grant one edge past HLOCK so the last locked transfer completes.
      lock_pend_d = locked;
`endif
    end
  end

  // State registers with asynchronous reset to the park master.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q      <= ParkGrant;
      addr_owner_q <= ParkIdx;
      data_owner_q <= ParkIdx;
      hold_cnt_q   <= '0;
`ifdef AHB_ARB_LOCK_EN
      lock_pend_q  <= 1'b0;
`endif
    end else begin
      grant_q      <= grant_d;
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      hold_cnt_q   <= hold_cnt_d;
`ifdef AHB_ARB_LOCK_EN
      lock_pend_q  <= lock_pend_d;
`endif
    end
  end

endmodule
